// File: rtl/frame_sched_if.sv
// frame_sched_if: frame control and pixel-read handshake bundle for frame_sched
interface frame_sched_if;
  logic        frame_start_i;
  logic [3:0]  reg_chan_cnt_i;
  logic [7:0]  reg_chan_len_i;
  logic        px_req_i;
  logic        chan_done_i;
  logic [3:0]  chan_sel_o;
  logic [15:0] chan_en_o;
  logic        ram_rd_en_o;
  logic [7:0]  ram_rd_addr_o;
  logic        px_vld_o;
  logic        px_last_o;
  logic        frame_busy_o;
  logic        frame_done_o;
  modport master (
    output frame_start_i, reg_chan_cnt_i, reg_chan_len_i, px_req_i, chan_done_i,
    input  chan_sel_o, chan_en_o, ram_rd_en_o, ram_rd_addr_o, px_vld_o, px_last_o,
           frame_busy_o, frame_done_o
  );
  modport slave (
    input  frame_start_i, reg_chan_cnt_i, reg_chan_len_i, px_req_i, chan_done_i,
    output chan_sel_o, chan_en_o, ram_rd_en_o, ram_rd_addr_o, px_vld_o, px_last_o,
           frame_busy_o, frame_done_o
  );
endinterface

// File: rtl/frame_sched.sv
// frame_sched: walks channels/pixels of a frame over the shared pixel RAM; RESET_GAP_EN adds a timed inter-frame GAP
module frame_sched #(
  parameter logic [15:0] GAP_CYCLES = 16'd10000
) (
  input logic clk_i,
  input logic rst_i,
  frame_sched_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  logic [2:0] state;
  logic [3:0] idx, cnt;
  logic [7:0] addr, len;
  logic       pend, vld, last, in_chan;
  assign in_chan           = state == S_LOAD || state == S_WAIT || state == S_READ || state == S_DRAIN;
  assign bus.chan_sel_o    = idx;
  assign bus.chan_en_o     = in_chan ? 16'd1 << idx : 16'd0;
  assign bus.ram_rd_en_o   = state == S_READ;
  assign bus.ram_rd_addr_o = addr;
  assign bus.px_vld_o      = vld;
  assign bus.px_last_o     = last;
  assign bus.frame_busy_o  = state != S_IDLE;
`ifdef RESET_GAP_EN
  localparam logic [2:0] S_GAP = 3'd5;
  logic [15:0] gcnt;
  logic        gap_end;
  assign gap_end          = state == S_GAP && gcnt == GAP_CYCLES - 16'd1;
  assign bus.frame_done_o = gap_end;
  // gap cycle counter, idle at zero outside GAP
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) gcnt <= '0;
    else gcnt <= (state == S_GAP && !gap_end) ? gcnt + 16'd1 : 16'd0;
`else
  logic done_q;
  assign bus.frame_done_o = done_q;
  // frame completes on the DRAIN->IDLE step of the last channel
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) done_q <= 1'b0;
    else done_q <= state == S_DRAIN && bus.chan_done_i && idx >= cnt;
`endif
  // frame/channel/pixel sequencing; extra start requests collapse into one pending flag
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
      addr  <= '0;
      len   <= '0;
      pend  <= 1'b0;
      vld   <= 1'b0;
      last  <= 1'b0;
    end else begin
      vld  <= state == S_READ;
      last <= state == S_READ && addr == len;
      pend <= state != S_IDLE && (pend || bus.frame_start_i);
      case (state)
        S_IDLE: if (bus.frame_start_i || pend) begin
          cnt   <= bus.reg_chan_cnt_i;
          len   <= bus.reg_chan_len_i;
          idx   <= '0;
          state <= S_LOAD;
        end
        S_LOAD: begin
          addr  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: if (bus.px_req_i) state <= S_READ;
        S_READ: if (addr == len) state <= S_DRAIN;
          else begin
            addr  <= addr + 8'd1;
            state <= S_WAIT;
          end
        S_DRAIN: if (bus.chan_done_i) begin
          if (idx < cnt) begin
            idx   <= idx + 4'd1;
            state <= S_LOAD;
          end
`ifdef RESET_GAP_EN
          else state <= S_GAP;
`else
          else state <= S_IDLE;
`endif
        end
`ifdef RESET_GAP_EN
        S_GAP: if (gap_end) state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_frame_sched.sv
// tb_frame_sched: directed and randomized checks of frame_sched against a queue-based frame model
module tb_frame_sched;
  localparam int GAP = 8;
`ifdef RESET_GAP_EN
  localparam int DLAT = 8;
  localparam int RESTART = 4;
`else
  localparam int DLAT = 1;
  localparam int RESTART = 3;
`endif
  localparam int IDLE = 0, LOAD = 1, WAIT = 2, READ = 3, DRAIN = 4, GAPS = 5;
  typedef struct packed { logic [3:0] ch; logic [7:0] ad; logic lst; } pix_t;
  logic clk = 1'b0, rst = 1'b1;
  frame_sched_if bus();
  frame_sched #(.GAP_CYCLES(16'(GAP))) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0, cyc = 0;
  pix_t q[$];
  pix_t cur;
  int ph = IDLE, gleft = 0;
  logic pend = 1'b0, mvld = 1'b0, mlast = 1'b0, mdone = 1'b0;
  logic [3:0] mch = '0;
  int req_pct = 0, done_pct = 0, fs_pct = 0, done_dly = 0, dcnt = 0;
  logic fs_force = 1'b0, req_force = 1'b0, rnd_regs = 1'b0;
  int rd_cyc[$], vld_cyc[$], done_cyc[$];
  logic [23:0] rd_log[$];
  logic vl_log[$];
  int cd_cyc = 0, req_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, a, e);
    end
  endtask

  task automatic mreset();
    q.delete();
    ph = IDLE; pend = 1'b0; mvld = 1'b0; mlast = 1'b0; mdone = 1'b0; mch = '0; gleft = 0;
  endtask

  task automatic zeros_chk(input string nm);
    chk(nm, 32'({bus.chan_sel_o, bus.chan_en_o, bus.ram_rd_en_o, bus.px_vld_o, bus.px_last_o,
                 bus.frame_busy_o, bus.frame_done_o}), 32'd0);
    chk({nm, "_addr"}, 32'(bus.ram_rd_addr_o), 32'd0);
  endtask

  task automatic cmp_all();
    logic [15:0] en_e;
    en_e = (ph >= LOAD && ph <= DRAIN) ? 16'd1 << mch : 16'd0;
    chk("busy", 32'(bus.frame_busy_o), 32'(ph != IDLE));
    chk("chan_sel", 32'(bus.chan_sel_o), 32'(mch));
    chk("chan_en", 32'(bus.chan_en_o), 32'(en_e));
    chk("rd_en", 32'(bus.ram_rd_en_o), 32'(ph == READ));
    if (ph == READ) chk("rd_addr", 32'(bus.ram_rd_addr_o), 32'(cur.ad));
    chk("px_vld", 32'(bus.px_vld_o), 32'(mvld));
    chk("px_last", 32'(bus.px_last_o), 32'(mlast));
`ifdef RESET_GAP_EN
    chk("frame_done", 32'(bus.frame_done_o), 32'(ph == GAPS && gleft == 1));
`else
    chk("frame_done", 32'(bus.frame_done_o), 32'(mdone));
`endif
  endtask

  // next-cycle model state from the inputs about to be sampled
  task automatic step();
    logic np, nv, nl, nd;
    np = (ph == IDLE) ? 1'b0 : (pend | bus.frame_start_i);
    nv = ph == READ;
    nl = ph == READ && cur.lst;
    nd = 1'b0;
    case (ph)
      IDLE: if (bus.frame_start_i || pend) begin
        q.delete();
        for (int c = 0; c <= int'(bus.reg_chan_cnt_i); c++)
          for (int a = 0; a <= int'(bus.reg_chan_len_i); a++)
            q.push_back('{ch: 4'(c), ad: 8'(a), lst: a == int'(bus.reg_chan_len_i)});
        cur = q.pop_front(); mch = cur.ch; ph = LOAD;
      end
      LOAD: ph = WAIT;
      WAIT: if (bus.px_req_i) ph = READ;
      READ: if (cur.lst) ph = DRAIN; else begin cur = q.pop_front(); ph = WAIT; end
      DRAIN: if (bus.chan_done_i) begin
        if (q.size() > 0) begin cur = q.pop_front(); mch = cur.ch; ph = LOAD; end
`ifdef RESET_GAP_EN
        else begin ph = GAPS; gleft = GAP; end
`else
        else begin ph = IDLE; nd = 1'b1; end
`endif
      end
      GAPS: begin gleft--; if (gleft == 0) ph = IDLE; end
      default: ph = IDLE;
    endcase
    pend = np; mvld = nv; mlast = nl; mdone = nd;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    cmp_all();
    if (bus.ram_rd_en_o) begin rd_cyc.push_back(cyc); rd_log.push_back({bus.chan_en_o, bus.ram_rd_addr_o}); end
    if (bus.px_vld_o) begin vld_cyc.push_back(cyc); vl_log.push_back(bus.px_last_o); end
    if (bus.frame_done_o) done_cyc.push_back(cyc);
    bus.frame_start_i = fs_force || (int'($urandom_range(0, 99)) < fs_pct);
    bus.px_req_i = req_force || (int'($urandom_range(0, 99)) < req_pct);
    bus.chan_done_i = (dcnt == 1) || (int'($urandom_range(0, 99)) < done_pct);
    if (dcnt > 0) dcnt--;
    if (done_dly > 0 && bus.px_vld_o && bus.px_last_o) dcnt = done_dly;
    if (bus.chan_done_i) cd_cyc = cyc;
    if (bus.px_req_i) req_cyc = cyc;
    if (rnd_regs) begin
      bus.reg_chan_cnt_i = (ph == IDLE) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      bus.reg_chan_len_i = (ph == IDLE) ? 8'($urandom_range(0, 7)) : 8'($urandom);
    end
    if (rst) mreset(); else step();
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); vld_cyc.delete(); done_cyc.delete(); rd_log.delete(); vl_log.delete();
  endtask

  task automatic start_frame(input logic [3:0] c, input logic [7:0] l);
    bus.reg_chan_cnt_i = c; bus.reg_chan_len_i = l;
    fs_force = 1'b1; cycle(); fs_force = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0, n;
    d0 = done_cyc.size(); n = 0;
    while (done_cyc.size() == d0 && n < budget) begin cycle(); n++; end
    chk(nm, 32'(done_cyc.size() > d0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    logic [23:0] eb[6];
    logic el[6];
    int found, ones;
    eb = '{24'h000100, 24'h000101, 24'h000102, 24'h000200, 24'h000201, 24'h000202};
    el = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bus.frame_start_i = 1'b0; bus.px_req_i = 1'b0; bus.chan_done_i = 1'b0;
    bus.reg_chan_cnt_i = '0; bus.reg_chan_len_i = '0;
    mreset();
    #12;
    zeros_chk("reset_state");
    @(negedge clk); rst = 1'b0;
    repeat (5) cycle();
    chk("idle_after_reset", 32'(bus.frame_busy_o), 32'd0);

    // two channels of three pixels, chan_done 3 cycles after each last pixel
    req_pct = 100; done_pct = 0; fs_pct = 0; done_dly = 3; clear_logs();
    start_frame(4'd1, 8'd2);
    wait_done("b_done_timeout", 200);
    repeat (20) cycle();
    chk("b_nrd", 32'(rd_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < rd_log.size(); i++) chk("b_rd_seq", 32'(rd_log[i]), 32'(eb[i]));
    for (int i = 0; i < 6 && i < vl_log.size(); i++) chk("b_last_seq", 32'(vl_log[i]), 32'(el[i]));
    chk("b_ndone", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) chk("b_done_lat", 32'(done_cyc[0] - cd_cyc), 32'(DLAT));

    // single px_req pulse while waiting
    req_pct = 0; done_dly = 2; clear_logs();
    start_frame(4'd0, 8'd1);
    repeat (5) cycle();
    req_force = 1'b1; cycle(); req_force = 1'b0;
    repeat (6) cycle();
    chk("c_nrd", 32'(rd_cyc.size()), 32'd1);
    if (rd_cyc.size() > 0) chk("c_rd_lat", 32'(rd_cyc[0] - req_cyc), 32'd1);
    if (vld_cyc.size() > 0) chk("c_vld_lat", 32'(vld_cyc[0] - req_cyc), 32'd2);
    req_pct = 100;
    wait_done("c_done_timeout", 100);
    repeat (12) cycle();

    // sixteen single-pixel channels
    done_dly = 1; clear_logs();
    start_frame(4'd15, 8'd0);
    wait_done("d_done_timeout", 400);
    repeat (12) cycle();
    chk("d_nrd", 32'(rd_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < rd_log.size(); i++) chk("d_rd_seq", 32'(rd_log[i]), 32'({16'd1 << i, 8'd0}));
    ones = 0;
    foreach (vl_log[i]) ones += int'(vl_log[i]);
    chk("d_all_last", 32'(ones), 32'd16);

    // three starts mid-frame collapse into one extra frame
    done_dly = 2; clear_logs();
    start_frame(4'd0, 8'd3);
    repeat (2) cycle();
    repeat (3) begin fs_force = 1'b1; cycle(); fs_force = 1'b0; cycle(); end
    wait_done("e_done1_timeout", 100);
    wait_done("e_done2_timeout", 100);
    repeat (40) cycle();
    chk("e_ndone", 32'(done_cyc.size()), 32'd2);
    chk("e_nrd", 32'(rd_cyc.size()), 32'd8);
    if (rd_cyc.size() > 4) chk("e_restart", 32'(rd_cyc[4] - done_cyc[0]), 32'(RESTART));

    // longest channel, no address wrap
    done_dly = 1; clear_logs();
    start_frame(4'd0, 8'd255);
    wait_done("g_done_timeout", 1000);
    repeat (12) cycle();
    chk("g_nrd", 32'(rd_log.size()), 32'd256);
    for (int i = 0; i < rd_log.size(); i++) chk("g_addr", 32'(rd_log[i][7:0]), 32'(i));
    chk("g_nlast", 32'(vl_log.size() > 0 ? int'(vl_log[vl_log.size() - 1]) : 0), 32'd1);

    // reset in READ of channel 3
    req_pct = 60; done_dly = 2; clear_logs();
    start_frame(4'd5, 8'd3);
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      cycle();
      if (ph == READ && mch == 4'd3) found = 1;
    end
    chk("f_reach", 32'(found), 32'd1);
    @(posedge clk); #1;
    chk("f_pre_rd", 32'({bus.ram_rd_en_o, bus.chan_sel_o}), 32'h13);
    rst = 1'b1; #1;
    zeros_chk("f_reset_now");
    mreset();
    bus.frame_start_i = 1'b0; bus.px_req_i = 1'b0; bus.chan_done_i = 1'b0; dcnt = 0;
    @(negedge clk); rst = 1'b0;
    req_pct = 100; done_pct = 50; clear_logs();
    repeat (30) cycle();
    chk("f_no_rd", 32'(rd_cyc.size()), 32'd0);
    chk("f_no_done", 32'(done_cyc.size()), 32'd0);
    chk("f_idle", 32'(bus.frame_busy_o), 32'd0);

    // randomized traffic, register churn during frames
    rnd_regs = 1'b1;
    for (int r = 0; r < 5; r++) begin
      req_pct = int'($urandom_range(20, 100));
      done_pct = int'($urandom_range(2, 12));
      fs_pct = int'($urandom_range(0, 6));
      done_dly = int'($urandom_range(0, 5));
      repeat (2500) cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 10000, giving the inter-frame latch gap length in clock cycles (16-bit).
REQ-002 SHALL have port clk_i  input  1  the single system clock; all state is on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port frame_start_i  input  1  one-cycle request to refresh all channels, driven from ram_wr_done.
REQ-005 SHALL have port reg_chan_cnt_i  input  4  number of channels minus 1.
REQ-006 SHALL have port reg_chan_len_i  input  8  number of pixels per channel minus 1.
REQ-007 SHALL have port px_req_i  input  1  the encoder is ready for the next pixel word.
REQ-008 SHALL have port chan_done_i  input  1  one-cycle pulse from the encoder when the last bit of the channel has been shifted.
REQ-009 SHALL have port chan_sel_o  output  4  index of the active channel.
REQ-010 SHALL have port chan_en_o  output  16  one-hot enable for the active channel; all zero when no channel is active.
REQ-011 SHALL have port ram_rd_en_o  output  1  read strobe to the shared pixel RAM read port.
REQ-012 SHALL have port ram_rd_addr_o  output  8  pixel RAM read address.
REQ-013 SHALL have port px_vld_o  output  1  RAM read data is valid for the encoder.
REQ-014 SHALL have port px_last_o  output  1  qualifies px_vld_o for the last pixel of the channel.
REQ-015 SHALL have port frame_busy_o  output  1  high in every state except IDLE.
REQ-016 SHALL have port frame_done_o  output  1  one-cycle pulse when the frame completes.

Function
REQ-017 SHALL implement the states IDLE, LOAD, WAIT, READ, DRAIN and GAP.
REQ-018 IDLE: on frame_start_i, or on a pending request, SHALL latch reg_chan_cnt_i and reg_chan_len_i, set the channel index to 0 and go to LOAD; register changes during a frame are ignored.
REQ-019 LOAD: SHALL set chan_sel_o, set the corresponding chan_en_o bit, set the pixel address to 0, and go to WAIT after 1 cycle.
REQ-020 WAIT: when px_req_i is high, SHALL assert ram_rd_en_o with ram_rd_addr_o equal to the current address on the next cycle and go to READ.
REQ-021 READ: SHALL assert px_vld_o exactly 1 cycle after ram_rd_en_o (RAM read latency 1), so px_req_i to px_vld_o is 2 cycles.
REQ-022 READ: SHALL assert px_last_o with px_vld_o when the address equals the latched length.
REQ-023 READ: for a non-last pixel, SHALL increment the address and go to WAIT; for the last pixel, SHALL go to DRAIN.
REQ-024 SHALL ignore px_req_i in READ and DRAIN, and SHALL assert ram_rd_en_o at most once per pixel.
REQ-025 DRAIN: on chan_done_i, if the channel index is below the latched count, SHALL increment the index and go to LOAD; otherwise SHALL go to GAP.
REQ-026 SHALL ignore chan_done_i outside DRAIN.
REQ-027 GAP: SHALL clear chan_en_o, count GAP_CYCLES cycles, then pulse frame_done_o and return to IDLE.
REQ-028 frame_start_i outside IDLE SHALL set a single pending flag; multiple requests SHALL collapse into one.
REQ-029 The pending flag SHALL be cleared when its frame starts, and that frame SHALL enter LOAD on the cycle after IDLE is entered.
REQ-030 Boundary, chan_len=0: exactly one pixel per channel, with px_last_o on the first px_vld_o.
REQ-031 Boundary, chan_len=255: addresses 0..255 with no wrap.
REQ-032 Boundary, chan_cnt=15: channels 0..15, and the index SHALL never wrap.
REQ-033 Boundary, chan_done_i and frame_start_i in the same cycle: both SHALL be honoured (advance and set pending).

Reset
REQ-034 rst_i high SHALL immediately force state IDLE, index 0, address 0, pending 0, gap counter 0.
REQ-035 rst_i high SHALL immediately force all outputs to 0, including mid-frame.
REQ-036 After reset release the block SHALL wait for a fresh frame_start_i.

Configuration
REQ-037 With macro RESET_GAP_EN defined, the GAP state SHALL behave as in REQ-027.
REQ-038 Without RESET_GAP_EN, DRAIN SHALL go directly to IDLE, pulsing frame_done_o on the transition, and GAP_CYCLES SHALL be unused.

Verification
REQ-039 chan_cnt=1, chan_len=2, px_req_i held high, chan_done_i 3 cycles after each last pixel -> addresses 0,1,2 on chan_en_o=0x0001, then 0x0002; px_last_o on address 2; frame_done_o once.
REQ-040 Single px_req_i pulse in WAIT -> ram_rd_en_o at +1 cycle, px_vld_o at +2 cycles, exactly one read.
REQ-041 chan_len=0, chan_cnt=15 -> 16 single-pixel channels with chan_sel_o 0..15, px_last_o on every px_vld_o, no index wrap.
REQ-042 Three frame_start_i pulses mid-frame -> exactly one extra frame starting right after frame_done_o.
REQ-043 rst_i asserted during READ of channel 3 -> all outputs 0 in the same cycle; no activity until the next frame_start_i.
REQ-044 RESET_GAP_EN with GAP_CYCLES=8 -> frame_done_o 8 cycles after the last chan_done_i; without the macro -> 1 cycle after.
